// File: rtl/prg_inject_loader.sv
`default_nettype none
// ============================================================================
// Module   : prg_inject_loader
// Brief    : PRG/cartridge loader from data_io to the SDRAM write port. Resolves
//            the load address, buffers payload bytes in a FIFO, writes them with
//            a req/ack handshake, then injects end-address zero-page pointers.
//            Optional auto-reset request: define LOADER_AUTORESET_EN.
// Revision : 1.0 - initial release
// ============================================================================
module prg_inject_loader #(
    parameter int AW     = 16,
    parameter int DEPTH  = 8,
    parameter int NPTR   = 8,
    parameter logic [((NPTR > 0) ? NPTR : 1)*AW-1:0] PTR_TABLE = {
        16'h002d, 16'h002e, 16'h002f, 16'h0030,
        16'h0031, 16'h0032, 16'h00ae, 16'h00af},
    parameter logic [AW-1:0] FIXED_BASE = 16'ha000,
    parameter logic [AW-1:0] AR_ADDR    = 16'ha000,
    parameter int AR_LEN = 4
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    input  logic          hdr_mode,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_data,
    output logic          mem_req,
    input  logic          mem_ack,
    output logic          busy,
    output logic          overflow,
    output logic [AW-1:0] end_addr,
    output logic          force_reset
);

    localparam int           c_PW        = $clog2(DEPTH);
    localparam logic [c_PW:0] c_FULL     = DEPTH[c_PW:0];
    localparam logic [c_PW:0] c_ONE      = {{c_PW{1'b0}}, 1'b1};
    localparam logic [4:0]   c_NPTR      = NPTR[4:0];
    localparam logic [4:0]   c_NPTR_LAST = c_NPTR - 5'd1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_DRAIN  = 3'd2,
        S_INJECT = 3'd3,
        S_RST    = 3'd4
    } state_t;

    state_t r_state, w_state_next;

    logic            r_dl_active_d;
    logic [AW-1:0]   r_addr;
    logic [AW-1:0]   r_fifo_addr [DEPTH];
    logic [7:0]      r_fifo_data [DEPTH];
    logic [c_PW:0]   r_wptr, r_rptr;
    logic            r_req;
    logic            r_overflow;
    logic [AW-1:0]   r_end_addr;
    logic [4:0]      r_ptr_idx;

    logic            w_dl_rise, w_dl_fall;
    logic [c_PW:0]   w_count;
    logic            w_fifo_empty, w_fifo_full;
    logic            w_in_inject, w_ack, w_fifo_pop;
    logic            w_wr_load, w_hdr0, w_hdr1;
    logic            w_push_req, w_push, w_drop;
    logic            w_src_valid, w_src_last, w_inj_done;
    logic [AW-1:0]   w_head_addr, w_ptr_addr, w_hdr_lo, w_hdr_hi;
    logic [7:0]      w_head_data, w_inj_data, w_end_hi;

    assign w_dl_rise    = dl_active & ~r_dl_active_d;
    assign w_dl_fall    = ~dl_active & r_dl_active_d;
    assign w_count      = r_wptr - r_rptr;
    assign w_fifo_empty = (w_count == '0);
    assign w_fifo_full  = (w_count == c_FULL);
    assign w_in_inject  = (r_state == S_INJECT);
    assign w_ack        = r_req & mem_ack;
    assign w_fifo_pop   = w_ack & ~w_in_inject;

    // Header bytes only steer the address; everything else is payload.
    assign w_wr_load  = dl_wr & (r_state == S_LOAD);
    assign w_hdr0     = hdr_mode & (dl_addr == '0);
    assign w_hdr1     = hdr_mode & (dl_addr == {{(AW-1){1'b0}}, 1'b1});
    assign w_push_req = w_wr_load & ~w_hdr0 & ~w_hdr1;
    assign w_push     = w_push_req & (~w_fifo_full | w_fifo_pop);
    assign w_drop     = w_push_req & ~w_push;

    assign w_hdr_lo = (r_addr & ~AW'(8'hff)) | AW'(dl_data);
    assign w_hdr_hi = (r_addr & ~(AW'(8'hff) << 8)) | (AW'(dl_data) << 8);

    assign w_head_addr = r_fifo_addr[r_rptr[c_PW-1:0]];
    assign w_head_data = r_fifo_data[r_rptr[c_PW-1:0]];

    assign w_end_hi   = 8'(r_end_addr >> 8);
    assign w_inj_data = r_ptr_idx[0] ? w_end_hi : r_end_addr[7:0];
    assign w_inj_done = (r_ptr_idx == c_NPTR);

    always_comb begin
        w_ptr_addr = '0;
        for (int i = 0; i < NPTR; i++) begin
            if (r_ptr_idx == 5'(i)) begin
                w_ptr_addr = PTR_TABLE[(NPTR-1-i)*AW +: AW];
            end
        end
    end

    // One request source at a time: FIFO head while loading/draining,
    // pointer table while injecting.
    assign w_src_valid = w_in_inject ? (r_ptr_idx < c_NPTR) : ~w_fifo_empty;
    assign w_src_last  = w_in_inject ? (r_ptr_idx == c_NPTR_LAST) : (w_count == c_ONE);

    assign mem_req  = r_req;
    assign mem_addr = r_req ? (w_in_inject ? w_ptr_addr : w_head_addr) : '0;
    assign mem_data = r_req ? (w_in_inject ? w_inj_data : w_head_data) : 8'h00;
    assign busy     = ~w_fifo_empty | (r_state != S_IDLE);
    assign overflow = r_overflow;
    assign end_addr = r_end_addr;

`ifdef LOADER_AUTORESET_EN
    localparam logic [15:0] c_RST_LAST = 16'(AR_LEN - 1);
    logic        r_ar;
    logic [15:0] r_rst_cnt;

    assign force_reset = (r_state == S_RST) & r_ar;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_ar      <= 1'b0;
            r_rst_cnt <= '0;
        end else begin
            if (r_state == S_IDLE && w_dl_rise) begin
                r_ar <= 1'b0;
            end
            if (w_ack && mem_addr == AR_ADDR) begin
                r_ar <= 1'b1;
            end
            if (r_state == S_RST) begin
                r_rst_cnt <= r_rst_cnt + 16'd1;
                if (w_state_next == S_IDLE) begin
                    r_ar      <= 1'b0;
                    r_rst_cnt <= '0;
                end
            end
        end
    end
`else
    assign force_reset = 1'b0;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_dl_rise) w_state_next = S_LOAD;
            S_LOAD:   if (w_dl_fall) w_state_next = S_DRAIN;
            S_DRAIN: begin
                if (w_fifo_empty && !r_req) begin
                    w_state_next = (NPTR > 0) ? S_INJECT : S_RST;
                end
            end
            S_INJECT: if (w_inj_done && !r_req) w_state_next = S_RST;
            S_RST: begin
`ifdef LOADER_AUTORESET_EN
                if (!r_ar || (r_rst_cnt == c_RST_LAST)) w_state_next = S_IDLE;
`else
                w_state_next = S_IDLE;
`endif
            end
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_dl_active_d <= 1'b0;
            r_addr        <= FIXED_BASE;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_req         <= 1'b0;
            r_overflow    <= 1'b0;
            r_end_addr    <= '0;
            r_ptr_idx     <= '0;
        end else begin
            r_dl_active_d <= dl_active;
            // Request stays up across back-to-back acks while more work is queued.
            r_req <= w_src_valid & ~(w_ack & w_src_last);

            if (r_state == S_IDLE && w_dl_rise) begin
                r_addr     <= FIXED_BASE;
                r_end_addr <= FIXED_BASE;
                r_overflow <= 1'b0;
            end

            if (w_wr_load) begin
                if (w_hdr0) begin
                    r_addr     <= w_hdr_lo;
                    r_end_addr <= w_hdr_lo;
                end else if (w_hdr1) begin
                    r_addr     <= w_hdr_hi;
                    r_end_addr <= w_hdr_hi;
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_fifo_pop) begin
                r_rptr     <= r_rptr + 1'b1;
                r_end_addr <= mem_addr + 1'b1;
            end

            if (r_state == S_DRAIN) begin
                r_ptr_idx <= '0;
            end else if (w_in_inject && w_ack) begin
                r_ptr_idx <= r_ptr_idx + 5'd1;
            end
        end
    end

    // Payload storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_fifo_addr[r_wptr[c_PW-1:0]] <= r_addr;
            r_fifo_data[r_wptr[c_PW-1:0]] <= dl_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prg_inject_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prg_inject_loader
// Brief    : Self-checking bench for prg_inject_loader with a write-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prg_inject_loader;

    localparam int DEPTH = 8;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [15:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic        hdr_mode = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic        busy;
    logic        overflow;
    logic [15:0] end_addr;
    logic        force_reset;

    prg_inject_loader dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .dl_active  (dl_active),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .hdr_mode   (hdr_mode),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .busy       (busy),
        .overflow   (overflow),
        .end_addr   (end_addr),
        .force_reset(force_reset)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ack_mode = 0;   // 0: always ack, 1: random ack, 2: never ack
    int fr_cycles = 0;
    int fr_first = 0;
    int last_wr = 0;
    wr_t obs_q[$];
    wr_t exp_q[$];
    logic [7:0] file_q[$];
    logic [15:0] ptr_tab [8] = '{16'h002d, 16'h002e, 16'h002f, 16'h0030,
                                 16'h0031, 16'h0032, 16'h00ae, 16'h00af};

    always @(posedge clk_sys) begin
        #1;
        case (ack_mode)
            0:       mem_ack = 1'b1;
            1:       mem_ack = ($urandom_range(0, 3) != 0);
            default: mem_ack = 1'b0;
        endcase
    end

    always @(negedge clk_sys) begin
        cyc = cyc + 1;
        if (mem_req && mem_ack) begin
            obs_q.push_back({mem_addr, mem_data});
            last_wr = cyc;
        end
        if (force_reset) begin
            if (fr_cycles == 0) fr_first = cyc;
            fr_cycles = fr_cycles + 1;
        end
    end

    // Reference: the list of memory writes a file should produce.
    task automatic model_build(input logic hdr, input int keep,
                               output logic [15:0] exp_end, output int exp_fr);
        logic [15:0] addr;
        int start;
        bit ar;
        exp_q.delete();
        addr  = 16'ha000;
        start = 0;
        if (hdr) begin
            if (file_q.size() > 0) addr[7:0]  = file_q[0];
            if (file_q.size() > 1) addr[15:8] = file_q[1];
            start = 2;
        end
        exp_end = addr;
        for (int i = start; i < file_q.size(); i++) begin
            if (i - start < keep) begin
                exp_q.push_back({addr, file_q[i]});
                exp_end = addr + 16'd1;
            end
            addr = addr + 16'd1;
        end
        ar = 1'b0;
        foreach (exp_q[i]) if (exp_q[i].a == 16'ha000) ar = 1'b1;
        for (int i = 0; i < 8; i++)
            exp_q.push_back({ptr_tab[i], (i % 2 == 1) ? exp_end[15:8] : exp_end[7:0]});
`ifdef LOADER_AUTORESET_EN
        exp_fr = ar ? 4 : 0;
`else
        exp_fr = 0;
`endif
    endtask

    task automatic clear_obs();
        obs_q.delete();
        fr_cycles = 0;
        fr_first  = 0;
        last_wr   = 0;
    endtask

    task automatic drive_file(input logic hdr, input int gapmax, input bit end_dl);
        @(posedge clk_sys); #1;
        hdr_mode  = hdr;
        dl_active = 1'b1;
        @(posedge clk_sys); #1;
        for (int i = 0; i < file_q.size(); i++) begin
            dl_wr   = 1'b1;
            dl_addr = 16'(i);
            dl_data = file_q[i];
            @(posedge clk_sys); #1;
            dl_wr = 1'b0;
            repeat ($urandom_range(0, gapmax)) begin
                @(posedge clk_sys); #1;
            end
        end
        if (end_dl) dl_active = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_sys);
            if (!busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Runs file_q through the DUT and checks every write and the final state.
    task automatic test_file(input string name, input logic hdr, input int amode, input int gapmax);
        logic [15:0] exp_end;
        int exp_fr;
        bit ok;
        model_build(hdr, 1 << 20, exp_end, exp_fr);
        clear_obs();
        ack_mode = amode;
        drive_file(hdr, gapmax, 1'b1);
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s idle: busy=%b after timeout, required 0", name, busy);
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL %s overflow: got %b required 0", name, overflow);
        end
        n_cmp++;
        if (end_addr !== exp_end) begin
            n_bad++;
            $display("FAIL %s end_addr: got %h required %h", name, end_addr, exp_end);
        end
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL %s write count: got %0d required %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL %s write %0d: got %h=%h required %h=%h", name, i,
                         obs_q[i].a, obs_q[i].d, exp_q[i].a, exp_q[i].d);
            end
        end
        n_cmp++;
        if (fr_cycles !== exp_fr) begin
            n_bad++;
            $display("FAIL %s force_reset cycles: got %0d required %0d", name, fr_cycles, exp_fr);
        end
        if (exp_fr > 0) begin
            n_cmp++;
            if (fr_first <= last_wr) begin
                n_bad++;
                $display("FAIL %s force_reset order: first at %0d, last write at %0d", name, fr_first, last_wr);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk_sys);
        n_cmp++;
        if ({mem_req, busy, overflow, force_reset} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset flags: got req/busy/ovf/fr=%b required 0000",
                     {mem_req, busy, overflow, force_reset});
        end
        n_cmp++;
        if (end_addr !== 16'h0000 || mem_addr !== 16'h0000 || mem_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset values: got end=%h addr=%h data=%h required zeros",
                     end_addr, mem_addr, mem_data);
        end
    endtask

    task automatic test_header_file();
        file_q = '{8'h01, 8'h10, 8'haa, 8'hbb, 8'hcc};
        test_file("hdr_file", 1'b1, 0, 0);
    endtask

    task automatic test_fixed_base();
        file_q = '{8'h11, 8'h22, 8'h33};
        test_file("fixed_base", 1'b0, 0, 1);
    endtask

    task automatic test_wrap();
        file_q = '{8'hff, 8'hff, 8'h5a, 8'h6b, 8'h7c};
        test_file("wrap", 1'b1, 1, 1);
    endtask

    task automatic test_header_only();
        file_q = '{8'h34, 8'h12};
        test_file("hdr_only", 1'b1, 0, 0);
    endtask

    task automatic test_overflow();
        logic [15:0] exp_end, held_a;
        logic [7:0] held_d;
        int exp_fr;
        bit ok;
        file_q.delete();
        for (int i = 0; i < DEPTH + 2; i++) file_q.push_back(8'($urandom));
        model_build(1'b0, DEPTH, exp_end, exp_fr);
        clear_obs();
        ack_mode = 2;
        drive_file(1'b0, 0, 1'b0);
        @(negedge clk_sys);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf flag: got %b required 1", overflow);
        end
        held_a = mem_addr;
        held_d = mem_data;
        n_cmp++;
        if (mem_req !== 1'b1 || held_a !== 16'ha000 || held_d !== file_q[0]) begin
            n_bad++;
            $display("FAIL ovf head: got req=%b %h=%h required 1 a000=%h", mem_req, held_a, held_d, file_q[0]);
        end
        dl_active = 1'b0;
        repeat (4) @(negedge clk_sys);
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== held_a || mem_data !== held_d) begin
            n_bad++;
            $display("FAIL ovf stall: got req=%b %h=%h required 1 %h=%h", mem_req, mem_addr, mem_data, held_a, held_d);
        end
        ack_mode = 1;
        wait_idle(ok);
        n_cmp++;
        if (!ok || obs_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL ovf write count: got %0d (idle=%b) required %0d", obs_q.size(), ok, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL ovf write %0d: got %h=%h required %h=%h", i,
                         obs_q[i].a, obs_q[i].d, exp_q[i].a, exp_q[i].d);
            end
        end
        n_cmp++;
        if (end_addr !== exp_end || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf end: got end=%h ovf=%b required %h 1", end_addr, overflow, exp_end);
        end
    endtask

    task automatic test_reset_mid_drain();
        file_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        clear_obs();
        ack_mode = 2;
        drive_file(1'b0, 0, 1'b1);
        repeat (2) begin
            @(posedge clk_sys); #1;
        end
        n_cmp++;
        if (mem_req !== 1'b1 || busy !== 1'b1 || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL drain setup: got req/busy/ovf=%b%b%b required 111", mem_req, busy, overflow);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({mem_req, busy, force_reset} !== 3'b000) begin
            n_bad++;
            $display("FAIL async reset: got req/busy/fr=%b required 000", {mem_req, busy, force_reset});
        end
        @(posedge clk_sys); #1;
        reset = 1'b0;
        clear_obs();
        file_q = '{8'h01, 8'h10, 8'haa, 8'hbb, 8'hcc};
        test_file("after_reset", 1'b1, 0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            logic hdr;
            int len;
            hdr = 1'($urandom_range(0, 1));
            len = hdr ? $urandom_range(2, 2 + DEPTH) : $urandom_range(0, DEPTH);
            file_q.delete();
            for (int i = 0; i < len; i++) file_q.push_back(8'($urandom));
            test_file($sformatf("random%0d", t), hdr, 1, 2);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_sys);
        #1 reset = 1'b0;
        test_reset();
        test_header_file();
        test_fixed_base();
        test_wrap();
        test_header_only();
        test_overflow();
        test_reset_mid_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
